// File: rtl/tmr_scrub_ctrl.sv
// Request controller for the TMR SRAM: user read/write port plus background scrub reads.
// Optional mismatch counter on scrub reads is enabled by defining TMR_SCRUB_ERR_CNT_EN.
module tmr_scrub_ctrl #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned SCRUB_INTERVAL = 1024,
  parameter int unsigned MAX_DEFER      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scrub_en_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              mem_enable_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef TMR_SCRUB_ERR_CNT_EN
  input  logic              mem_mismatch_i,
  output logic [15:0]       err_count_o,
`endif
  output logic [ADDR_W-1:0] scrub_addr_o,
  output logic              scrub_pass_done_o
);

  localparam int unsigned TimerW = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int unsigned DeferW = $clog2(MAX_DEFER + 1);
  localparam logic [TimerW-1:0] TimerReload = TimerW'(SCRUB_INTERVAL - 1);
  localparam logic [DeferW-1:0] DeferMax    = DeferW'(MAX_DEFER);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdHold, StSc, StScHold} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                pending_q, pending_d;
  logic [DeferW-1:0]   defer_q, defer_d;
  logic [ADDR_W-1:0]   scrub_addr_q, scrub_addr_d;
  logic                pass_done_q, pass_done_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic accept;
  logic sc_done;
  logic in_scrub;

  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    accept      = req_valid_i & req_ready_q;
    sc_done     = (state_q == StScHold);
    in_scrub    = (state_q == StSc) || (state_q == StScHold);

    // req_ready_q is already low when the defer counter has saturated, so a
    // pending scrub is the only way out of idle in that case.
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          lat_addr_d  = req_addr_i;
          lat_wdata_d = req_wdata_i;
          state_d     = req_we_i ? StWr : StRd;
        end else if (pending_q && scrub_en_i) begin
          state_d = StSc;
        end
      end
      StWr:     state_d = StIdle;
      StRd:     state_d = StRdHold;
      StRdHold: state_d = StIdle;
      StSc:     state_d = StScHold;
      StScHold: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    timer_d   = TimerReload;
    pending_d = 1'b0;
    defer_d   = '0;
    if (scrub_en_i) begin
      timer_d   = (timer_q == '0) ? TimerReload : timer_q - TimerW'(1);
      pending_d = (timer_q == '0) | (pending_q & ~sc_done);
      if (sc_done) begin
        defer_d = '0;
      end else if (pending_q && !in_scrub && (defer_q != DeferMax)) begin
        defer_d = defer_q + DeferW'(1);
      end else begin
        defer_d = defer_q;
      end
    end

    scrub_addr_d = sc_done ? scrub_addr_q + ADDR_W'(1) : scrub_addr_q;
    pass_done_d  = sc_done && (&scrub_addr_q);

    req_ready_d = (state_d == StIdle) && (defer_d != DeferMax);
    rsp_valid_d = (state_q == StRdHold);
    rsp_rdata_d = (state_q == StRdHold) ? mem_rdata_i : rsp_rdata_q;

    // Memory drive is registered, so it is decoded from the upcoming state.
    mem_enable_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    unique case (state_d)
      StWr: begin
        mem_enable_d = 1'b1;
        mem_we_d     = 1'b1;
        mem_addr_d   = lat_addr_d;
        mem_wdata_d  = lat_wdata_d;
      end
      StRd, StRdHold: begin
        mem_enable_d = 1'b1;
        mem_addr_d   = lat_addr_d;
      end
      StSc, StScHold: begin
        mem_enable_d = 1'b1;
        mem_addr_d   = scrub_addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      timer_q      <= TimerReload;
      pending_q    <= 1'b0;
      defer_q      <= '0;
      scrub_addr_q <= '0;
      pass_done_q  <= 1'b0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      mem_enable_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      defer_q      <= defer_d;
      scrub_addr_q <= scrub_addr_d;
      pass_done_q  <= pass_done_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      mem_enable_q <= mem_enable_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

`ifdef TMR_SCRUB_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == StScHold) && mem_mismatch_i && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

  assign req_ready_o       = req_ready_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_rdata_o       = rsp_rdata_q;
  assign mem_enable_o      = mem_enable_q;
  assign mem_we_o          = mem_we_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_wdata_o       = mem_wdata_q;
  assign scrub_addr_o      = scrub_addr_q;
  assign scrub_pass_done_o = pass_done_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: vector table of user transactions plus scrub, wrap,
// starvation and reset corner sequences against a small TMR memory model.
module tb_tmr_scrub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scrub_en = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       mem_enable;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_mismatch;
  logic [7:0] scrub_addr;
  logic       scrub_pass_done;
`ifdef TMR_SCRUB_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tmr_scrub_ctrl #(
    .ADDR_W        (8),
    .DATA_W        (8),
    .SCRUB_INTERVAL(4),
    .MAX_DEFER     (16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .scrub_en_i       (scrub_en),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_we_i         (req_we),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .rsp_valid_o      (rsp_valid),
    .rsp_rdata_o      (rsp_rdata),
    .mem_enable_o     (mem_enable),
    .mem_we_o         (mem_we),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_rdata_i      (mem_rdata),
`ifdef TMR_SCRUB_ERR_CNT_EN
    .mem_mismatch_i   (mem_mismatch),
    .err_count_o      (err_count),
`endif
    .scrub_addr_o     (scrub_addr),
    .scrub_pass_done_o(scrub_pass_done)
  );

  // TMR memory model: synchronous voted read, write-back on the held second read cycle.
  logic [7:0] c0 [256];
  logic [7:0] c1 [256];
  logic [7:0] c2 [256];
  logic [7:0] rd_addr_q = '0;
  logic       rd_vld_q = 1'b0;
  logic       corrupt = 1'b0;

  function automatic logic [7:0] vote(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign mem_mismatch = rd_vld_q && ((c0[rd_addr_q] != c1[rd_addr_q]) ||
                                     (c1[rd_addr_q] != c2[rd_addr_q]));

  always @(posedge clk) begin
    if (corrupt) begin
      c1[0] <= 8'h00;
    end else if (mem_enable && mem_we) begin
      c0[mem_addr] <= mem_wdata;
      c1[mem_addr] <= mem_wdata;
      c2[mem_addr] <= mem_wdata;
    end else if (mem_enable) begin
      mem_rdata <= vote(c0[mem_addr], c1[mem_addr], c2[mem_addr]);
      if (mem_mismatch && (rd_addr_q == mem_addr)) begin
        c0[mem_addr] <= vote(c0[mem_addr], c1[mem_addr], c2[mem_addr]);
        c1[mem_addr] <= vote(c0[mem_addr], c1[mem_addr], c2[mem_addr]);
        c2[mem_addr] <= vote(c0[mem_addr], c1[mem_addr], c2[mem_addr]);
      end
    end
    rd_addr_q <= mem_addr;
    rd_vld_q  <= mem_enable && !mem_we;
  end

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    chk(name, 32'(req_ready), 1);
  endtask

  task automatic xact(input vec_t v, input int idx);
    wait_ready($sformatf("v%0d ready", idx));
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    tick();
    req_valid = 1'b0;
    chk($sformatf("v%0d T+1 enable", idx), 32'(mem_enable), 1);
    chk($sformatf("v%0d T+1 we", idx), 32'(mem_we), 32'(v.we));
    chk($sformatf("v%0d T+1 addr", idx), 32'(mem_addr), 32'(v.addr));
    if (v.we) begin
      chk($sformatf("v%0d T+1 wdata", idx), 32'(mem_wdata), 32'(v.wdata));
      tick();
      chk($sformatf("v%0d T+2 ready", idx), 32'(req_ready), 1);
    end else begin
      chk($sformatf("v%0d T+1 rsp_valid", idx), 32'(rsp_valid), 0);
      tick();
      chk($sformatf("v%0d T+2 drive", idx), {22'd0, mem_enable, mem_we, mem_addr},
          {22'd0, 1'b1, 1'b0, v.addr});
      chk($sformatf("v%0d T+2 rsp_valid", idx), 32'(rsp_valid), 0);
      tick();
      chk($sformatf("v%0d T+3 rsp", idx), {23'd0, rsp_valid, rsp_rdata},
          {23'd0, 1'b1, v.exp_rdata});
      tick();
      chk($sformatf("v%0d T+4 rsp_valid", idx), 32'(rsp_valid), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int pulses;
    int rsp_cnt;
    logic [7:0] addr_at_pulse;
    logic ready_prev;
    logic ready_before_sc;
    logic any_rsp;

    vecs[0] = '{1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 8'hFF, 8'h5A, 8'h00};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'h5A};
    vecs[4] = '{1'b1, 8'h10, 8'h3C, 8'h00};
    vecs[5] = '{1'b0, 8'h10, 8'h00, 8'h3C};
    vecs[6] = '{1'b1, 8'h00, 8'h3C, 8'h00};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h3C};

    // Reset state
    tick();
    tick();
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset mem drive", {14'd0, mem_enable, mem_we, mem_addr, mem_wdata}, 0);
    chk("reset rsp", {23'd0, rsp_valid, rsp_rdata}, 0);
    chk("reset scrub", {23'd0, scrub_pass_done, scrub_addr}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      xact(vecs[i], i);
    end

    // Scrub repairs a single diverged copy at address 0
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    scrub_en = 1'b1;
    w = 0;
    while (!mem_enable && w < 20) begin
      tick();
      w++;
    end
    chk("scrub SC drive", {22'd0, mem_enable, mem_we, mem_addr}, {22'd0, 1'b1, 1'b0, 8'h00});
    scrub_en = 1'b0;
    tick();
    chk("scrub SC_HOLD drive", {22'd0, mem_enable, mem_we, mem_addr},
        {22'd0, 1'b1, 1'b0, 8'h00});
    tick();
    chk("scrub addr after", 32'(scrub_addr), 1);
    chk("scrub no rsp", 32'(rsp_valid), 0);
    chk("scrub copy0", 32'(c0[0]), 32'h3C);
    chk("scrub copy1", 32'(c1[0]), 32'h3C);
    chk("scrub copy2", 32'(c2[0]), 32'h3C);
`ifdef TMR_SCRUB_ERR_CNT_EN
    chk("err_count after scrub", 32'(err_count), 1);
`endif

    // Sweep wrap
    scrub_en = 1'b1;
    pulses = 0;
    addr_at_pulse = 8'hAA;
    w = 0;
    while (pulses == 0 && w < 3000) begin
      tick();
      w++;
      if (scrub_pass_done) begin
        pulses++;
        addr_at_pulse = scrub_addr;
      end
    end
    scrub_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (scrub_pass_done) pulses++;
    end
    chk("wrap pulse count", 32'(pulses), 1);
    chk("wrap addr at pulse", 32'(addr_at_pulse), 0);
    chk("wrap addr after", 32'(scrub_addr), 0);

    // Starvation bound under back-to-back reads
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h10;
    scrub_en  = 1'b1;
    rsp_cnt = 0;
    ready_prev = req_ready;
    ready_before_sc = 1'b1;
    w = 0;
    while (!(mem_enable && mem_addr == 8'h00) && w < 40) begin
      ready_prev = req_ready;
      tick();
      w++;
      if (rsp_valid) rsp_cnt++;
    end
    ready_before_sc = ready_prev;
    chk("starve SC entered", 32'(mem_enable && mem_addr == 8'h00 && !mem_we), 1);
    chk("starve within bound", 32'(w <= 24), 1);
    chk("starve ready low before SC", 32'(ready_before_sc), 0);
    chk("starve user reads served", 32'(rsp_cnt > 0), 1);
    req_valid = 1'b0;
    scrub_en  = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("starve scrub advanced", 32'(scrub_addr), 1);

    // Reset during RD_HOLD
    wait_ready("rstrd ready");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'hFF;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstrd in RD_HOLD", 32'(mem_enable), 1);
    rst = 1'b1;
    tick();
    chk("rstrd state", {21'd0, rsp_valid, mem_enable, req_ready, scrub_addr}, 0);
`ifdef TMR_SCRUB_ERR_CNT_EN
    chk("rstrd err_count", 32'(err_count), 0);
`endif
    tick();
    rst = 1'b0;
    any_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_rsp = any_rsp | rsp_valid;
    end
    chk("rstrd no response", 32'(any_rsp), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_ctrl.md
Name: tmr_scrub_ctrl

Overview:
- Upstream request controller for the 2 kbit TMR SRAM. It is the only driver of the memory's enable, we, addr and data_in, and it takes the voted data_out back.
- Converts a single-outstanding user valid/ready request port into memory cycles.
- Periodically inserts background scrub reads that sweep all 256 addresses. Each read holds the address for a second cycle, so the memory's mismatch write-back repairs any diverged copy.

Parameters:
ADDR_W, 8, memory address width (depth = 2**ADDR_W)
DATA_W, 8, data width
SCRUB_INTERVAL, 1024, cycles between scrub requests (>=2)
MAX_DEFER, 16, cycles a pending scrub may be deferred by user traffic before it is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
scrub_en  in  1  enables background scrubbing
req_valid  in  1  user request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  user address
req_wdata  in  DATA_W  user write data
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_rdata  out  DATA_W  read data
mem_enable  out  1  to memory enable
mem_we  out  1  to memory we
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  DATA_W  to memory data_in
mem_rdata  in  DATA_W  voted memory data_out
scrub_addr  out  ADDR_W  next address to scrub
scrub_pass_done  out  1  one-cycle pulse when the sweep wraps

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state IDLE
  - all outputs 0
  - scrub_addr 0
  - interval timer loaded with SCRUB_INTERVAL-1
  - scrub pending flag 0
  - defer counter 0
- All mem_* outputs are registered. In IDLE: mem_enable=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FSM states: IDLE, WR, RD, RD_HOLD, SC, SC_HOLD.
- IDLE behaviour:
  - req_ready=1 only in IDLE and when not forced (defer counter < MAX_DEFER).
  - A request is accepted on req_valid & req_ready. Address and data are latched.
  - Next state is WR if req_we, otherwise RD.
  - If there is no accept and the scrub is pending, next state is SC.
  - User traffic wins over a pending scrub unless forced.
- WR (1 cycle): mem_enable=1, mem_we=1, mem_addr/mem_wdata = latched values. Then IDLE. Write cost = 2 cycles from accept to the next possible accept.
- RD (1 cycle): mem_enable=1, mem_we=0, mem_addr = latched address. Then RD_HOLD.
- RD_HOLD (1 cycle):
  - Same drive as RD with the address held, so memory write-back corrects mismatched copies at that address.
  - mem_rdata is captured.
  - rsp_valid=1 and rsp_rdata = captured value in the following cycle (accept at T gives response at T+3).
  - Then IDLE.
- SC / SC_HOLD: identical drive to RD / RD_HOLD using scrub_addr. No rsp_valid.
- On leaving SC_HOLD:
  - scrub_addr increments modulo 2**ADDR_W.
  - Pending flag and defer counter clear.
  - On wrap (255 to 0), scrub_pass_done pulses in the cycle after SC_HOLD.
- Interval timer:
  - Decrements each cycle while scrub_en=1.
  - At 0 it sets pending and reloads. If pending is already set, it stays set; there is no queueing of multiple scrubs.
- scrub_en=0: timer reloads, pending and defer counter clear, scrub_addr holds. An in-flight SC/SC_HOLD completes.
- Defer counter:
  - Increments each cycle while pending and state is not SC/SC_HOLD, saturating at MAX_DEFER.
  - At MAX_DEFER, req_ready=0 and IDLE goes to SC.
- rst asserted mid-operation: returns to reset values next edge. No response is issued for an aborted read.
- req_* inputs are ignored when req_ready=0.

Optional Feature:
- Macro: TMR_SCRUB_ERR_CNT_EN.
- Defined:
  - Adds input mem_mismatch (1 bit, OR of the three copy mismatch flags) and output err_count (16 bits).
  - err_count increments by 1 on every SC_HOLD cycle with mem_mismatch=1, saturating at 0xFFFF.
  - Reset to 0 by rst.
- Undefined: neither port exists, and there is no counter logic.

Test Plan:
- Reset then write: after rst, req_we=1, addr=0x10, wdata=0xA5 accepted at T. Required: mem_enable=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 at T+1; req_ready=1 again at T+2.
- Read latency: read addr 0x10 accepted at T with 0xA5 stored. Required: mem_addr=0x10 at T+1 and T+2 with mem_we=0; rsp_valid=1, rsp_rdata=0xA5 at T+3 only.
- Scrub correction: SCRUB_INTERVAL=4, scrub_en=1, one copy of addr 0 forced to 0x00 while the others hold 0x3C. Required: scrub issues SC/SC_HOLD at addr 0; afterwards all copies read 0x3C; scrub_addr=1.
- Sweep wrap: scrub_addr preset path through 256 scrubs. Required: scrub_pass_done pulses exactly once, scrub_addr returns to 0.
- Starvation bound: MAX_DEFER=16, scrub pending, req_valid held 1 with back-to-back reads. Required: req_ready drops within 16 cycles of pending and SC is entered.
- Reset mid-read: rst during RD_HOLD. Required: no rsp_valid pulse, mem_enable=0 next cycle, scrub_addr=0; with TMR_SCRUB_ERR_CNT_EN, err_count=0.
